// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage: PC, word-addressed instruction memory, IF/ID register.
module if_stage #(
  parameter int          IMEM_DEPTH = 256,
  parameter int          ADDR_W     = 8,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              stall,
  input  logic              pc_src,
  input  logic [31:0]       branch_target,
  input  logic              jump,
  input  logic [31:0]       jump_target,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_waddr,
  input  logic [31:0]       imem_wdata,
  output logic [31:0]       pc,
  output logic [31:0]       if_id_instr,
  output logic [31:0]       if_id_pc_plus4,
  output logic              halted
);

  typedef enum logic {FETCH = 1'b0, HALTED = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] fetch_word;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] redirect_target;

  // Combinational read of the old contents gives read-before-write on a same-address load.
  assign fetch_word      = imem[pc_q[ADDR_W+1:2]];
  assign pc_plus4        = pc_q + 32'd4;
  assign redirect        = pc_src | jump;
  assign redirect_target = jump ? jump_target : branch_target;

  always_ff @(posedge clk) begin
    if (imem_we) begin
      imem[imem_waddr] <= imem_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (enable && !stall) begin
      case (state_q)
        FETCH: begin
          if (redirect) begin
            pc_d    = redirect_target;
            instr_d = 32'd0;
            pc4_d   = 32'd0;
          end else begin
            instr_d = fetch_word;
            pc4_d   = pc_plus4;
            // The halt word is latched but the PC parks on it.
            if (fetch_word == HALT_WORD) begin
              state_d = HALTED;
            end else begin
              pc_d = pc_plus4;
            end
          end
        end
        HALTED: begin
          instr_d = 32'd0;
          pc4_d   = 32'd0;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      pc_q    <= 32'd0;
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign pc             = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc_plus4 = pc4_q;
  assign halted         = (state_q == HALTED);

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage with a behavioural fetch model.
module tb_if_stage;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        stall = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'd0;
  logic        imem_we = 1'b0;
  logic [7:0]  imem_waddr = 8'd0;
  logic [31:0] imem_wdata = 32'd0;
  logic [31:0] pc, if_id_instr, if_id_pc_plus4;
  logic        halted;

  if_stage dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .stall(stall),
    .pc_src(pc_src), .branch_target(branch_target), .jump(jump),
    .jump_target(jump_target), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .pc(pc), .if_id_instr(if_id_instr),
    .if_id_pc_plus4(if_id_pc_plus4), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        halted;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference model: a program memory plus the architectural fetch state.
  logic [31:0] m_mem [256];
  logic [31:0] m_pc, m_instr, m_pc4;
  bit          m_halt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_instr = 0; m_pc4 = 0; m_halt = 0;
  endtask

  task automatic step(input bit en, input bit st, input bit ps, input logic [31:0] bt,
                      input bit j, input logic [31:0] jt, input bit we,
                      input logic [7:0] wa, input logic [31:0] wd);
    logic [31:0] fw;
    @(negedge clk);
    enable = en; stall = st; pc_src = ps; branch_target = bt;
    jump = j; jump_target = jt; imem_we = we; imem_waddr = wa; imem_wdata = wd;
    fw = m_mem[m_pc[9:2]];
    if (en && !st) begin
      if (m_halt) begin
        m_instr = 0; m_pc4 = 0;
      end else if (j || ps) begin
        m_pc = j ? jt : bt; m_instr = 0; m_pc4 = 0;
      end else begin
        m_instr = fw; m_pc4 = m_pc + 4;
        if (fw == HALT) m_halt = 1;
        else m_pc = m_pc + 4;
      end
    end
    if (we) m_mem[wa] = wd;
    sb.push_back('{m_pc, m_instr, m_pc4, m_halt});
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    enable = 0; imem_we = 0; stall = 0; pc_src = 0; jump = 0;
    #2 reset_n = 0;
    #1;
    chk("rst_pc", pc, 32'd0);
    chk("rst_instr", if_id_instr, 32'd0);
    chk("rst_pc4", if_id_pc_plus4, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    model_reset();
    reset_n = 1;
    sb.push_back('{m_pc, m_instr, m_pc4, m_halt});
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("pc", pc, mon_e.pc);
      chk("if_id_instr", if_id_instr, mon_e.instr);
      chk("if_id_pc_plus4", if_id_pc_plus4, mon_e.pc4);
      chk("halted", {31'd0, halted}, {31'd0, mon_e.halted});
    end
  end

  initial begin
    logic [31:0] prog [4];
    logic [31:0] w, bt, jt;
    bit          en, st, ps, j, we;
    int          drain;
    prog[0] = 32'h2008_0001; prog[1] = 32'h2009_0002;
    prog[2] = 32'h0109_5020; prog[3] = HALT;

    #1;
    chk("init_pc", pc, 32'd0);
    chk("init_instr", if_id_instr, 32'd0);
    chk("init_halted", {31'd0, halted}, 32'd0);
    model_reset();
    #1 reset_n = 1;

    // Program load with the pipeline disabled.
    for (int i = 0; i < 256; i++) begin
      w = (i < 4) ? prog[i] : $urandom;
      if (i >= 4 && w == HALT) w = 32'h1;
      step(0, 0, 0, 0, 0, 0, 1, i[7:0], w);
    end
    chk("load_pc", pc, 32'd0);

    run(4);
    chk("halt_pc", pc, 32'd12);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_instr", if_id_instr, HALT);
    chk("halt_pc4", if_id_pc_plus4, 32'd16);
    run(2);
    chk("halted_nop", if_id_instr, 32'd0);
    chk("halted_pc", pc, 32'd12);

    rst_pulse(); run(2);
    chk("pre_stall_pc", pc, 32'd8);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("stall1_pc", pc, 32'd8);
    chk("stall1_instr", if_id_instr, prog[1]);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("stall2_pc", pc, 32'd8);
    run(1);
    chk("resume_pc", pc, 32'd12);
    chk("resume_instr", if_id_instr, prog[2]);

    rst_pulse(); run(2);
    step(1, 0, 1, 32'h40, 0, 0, 0, 0, 0);
    chk("br_pc", pc, 32'h40);
    chk("br_bubble", if_id_instr, 32'd0);
    run(1);
    chk("br_pc4", if_id_pc_plus4, 32'h44);

    rst_pulse(); run(2);
    step(1, 0, 1, 32'h40, 1, 32'h80, 0, 0, 0);
    chk("jmp_prio_pc", pc, 32'h80);
    rst_pulse(); run(2);
    step(1, 1, 1, 32'h40, 1, 32'h80, 0, 0, 0);
    chk("stall_vs_redirect_pc", pc, 32'd8);

    rst_pulse(); run(3);
    chk("pre_squash_pc", pc, 32'd12);
    step(1, 0, 0, 0, 1, 32'h20, 0, 0, 0);
    chk("squash_halted", {31'd0, halted}, 32'd0);
    chk("squash_instr", if_id_instr, 32'd0);
    chk("squash_pc", pc, 32'h20);
    rst_pulse();

    step(0, 0, 0, 0, 0, 0, 1, 8'd9, 32'hCAFE_0001);
    chk("dis_write_pc", pc, 32'd0);
    step(1, 0, 0, 0, 0, 0, 1, 8'd0, 32'hABCD_0002);
    chk("rbw_instr", if_id_instr, prog[0]);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst_pulse();
        continue;
      end
      en = ($urandom_range(0, 4) != 0);
      st = ($urandom_range(0, 4) == 0);
      ps = ($urandom_range(0, 9) == 0);
      j  = ($urandom_range(0, 11) == 0);
      bt = $urandom_range(0, 1023);
      jt = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 1023);
      if ($urandom_range(0, 19) == 0) jt = 32'hFFFF_FFFC;
      we = ($urandom_range(0, 9) == 0);
      w  = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
      step(en, st, ps, bt, j, jt, we, 8'($urandom), w);
    end

    drain = 0;
    while (sb.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #2;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
